// File: rtl/vm_pkg.sv
// Shared definitions for the change dispenser: FSM state codes, pulse generator phases,
// frame geometry and coin denominations.
package vm_pkg;

    localparam int FRAME_BEATS = 6;
    localparam int MAX_ITEM    = 6;
    localparam int NUM_COINS   = 5;

    // Hopper index: 0=50, 1=20, 2=10, 3=5, 4=1
    typedef logic [2:0] coin_idx_t;

    localparam logic [6:0] DENOM [NUM_COINS] = '{7'd50, 7'd20, 7'd10, 7'd5, 7'd1};

    // Dispenser FSM states
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CAPTURE    = 3'd1;
    localparam logic [2:0] ST_ITEM_PULSE = 3'd2;
    localparam logic [2:0] ST_ITEM_WAIT  = 3'd3;
    localparam logic [2:0] ST_COIN_SEL   = 3'd4;
    localparam logic [2:0] ST_COIN_PULSE = 3'd5;
    localparam logic [2:0] ST_COIN_WAIT  = 3'd6;
    localparam logic [2:0] ST_DONE       = 3'd7;

    // Pulse generator phases
    localparam logic [1:0] PG_IDLE  = 2'd0;
    localparam logic [1:0] PG_PULSE = 2'd1;
    localparam logic [1:0] PG_WAIT  = 2'd2;

    // Value of one coin from hopper idx, widened to the payout accumulator width
    function automatic logic [10:0] denom_value(input coin_idx_t idx);
        logic [10:0] v;
        v = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (idx == coin_idx_t'(i)) v = {4'b0, DENOM[i]};
        end
        return v;
    endfunction

endpackage

// File: rtl/vm_pulse_gen.sv
// One-unit handshake engine: a start strobe launches a PULSE_W-cycle pulse, then waits for an
// ack. With DISP_TIMEOUT_EN defined the wait gives up after ACK_TIMEOUT cycles.
module vm_pulse_gen
    import vm_pkg::*;
#(
    parameter int unsigned PULSE_W     = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_ack,
    output logic o_pulse,
    output logic o_pulse_last,
    output logic o_ack_seen,
    output logic o_timeout
);

    localparam int unsigned PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    logic [1:0]     r_phase;
    logic [PCW-1:0] r_pcnt;

    assign o_pulse      = (r_phase == PG_PULSE);
    assign o_pulse_last = o_pulse && (r_pcnt == PCW'(PULSE_W - 1));
    assign o_ack_seen   = (r_phase == PG_WAIT) && i_ack;

    // Phase sequencing; a start always restarts the pulse from its first cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= PG_IDLE;
            r_pcnt  <= '0;
        end else if (i_start) begin
            r_phase <= PG_PULSE;
            r_pcnt  <= '0;
        end else begin
            case (r_phase)
                PG_PULSE: begin
                    if (o_pulse_last) r_phase <= PG_WAIT;
                    else              r_pcnt  <= r_pcnt + PCW'(1);
                end
                PG_WAIT: begin
                    if (o_ack_seen || o_timeout) r_phase <= PG_IDLE;
                end
                default: r_phase <= PG_IDLE;
            endcase
        end
    end

`ifdef DISP_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(ACK_TIMEOUT + 1);

    logic [TCW-1:0] r_wcnt;

    // Wait-cycle counter, zero on the first wait cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_wcnt <= '0;
        else if (r_phase != PG_WAIT)    r_wcnt <= '0;
        else                            r_wcnt <= r_wcnt + TCW'(1);
    end

    assign o_timeout = (r_phase == PG_WAIT) && !i_ack && (r_wcnt == TCW'(ACK_TIMEOUT - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (ACK_TIMEOUT == 0);
    assign o_timeout    = 1'b0;
`endif

endmodule

// File: rtl/vm_change_dispenser.sv
// Change dispenser: captures the 6-beat result frame, vends the item, then ejects coins largest
// denomination first, one pulse/ack handshake per unit. Optional DISP_TIMEOUT_EN adds an ack
// timeout that abandons the remaining payout and raises a sticky fault.
module vm_change_dispenser
    import vm_pkg::*;
#(
    parameter int unsigned PULSE_W     = 4,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  in_data,
    output logic        item_req,
    output logic [2:0]  item_id,
    input  logic        item_ack,
    output logic [2:0]  coin_sel,
    output logic        coin_pulse,
    input  logic        coin_ack,
    output logic        busy,
    output logic        done,
    output logic        frame_err,
    output logic        frame_drop,
    output logic [10:0] dispensed_total,
    output logic        fault
);

    logic [2:0]  r_state;
    logic [2:0]  r_beat_cnt;
    logic [3:0]  r_item;
    logic [3:0]  r_cnt [NUM_COINS];
    coin_idx_t   r_sel;
    logic [10:0] r_total;
    logic        r_frame_err;
    logic        r_frame_drop;
    logic        r_drop_run;

    logic [2:0]  w_state_d;
    logic        w_err;
    logic        w_pg_start;
    logic        w_pick_valid;
    coin_idx_t   w_pick;
    logic        w_accept;
    logic        w_drop_beat;
    logic        w_pg_ack_in;
    logic        w_pg_pulse;
    logic        w_pg_last;
    logic        w_pg_ack;
    logic        w_pg_tmo;

    vm_pulse_gen #(
        .PULSE_W     (PULSE_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_pulse_gen (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_pg_start),
        .i_ack        (w_pg_ack_in),
        .o_pulse      (w_pg_pulse),
        .o_pulse_last (w_pg_last),
        .o_ack_seen   (w_pg_ack),
        .o_timeout    (w_pg_tmo)
    );

    // Only the ack belonging to the current wait state reaches the handshake engine
    assign w_pg_ack_in = ((r_state == ST_ITEM_WAIT) && item_ack) ||
                         ((r_state == ST_COIN_WAIT) && coin_ack);

    assign w_accept    = in_valid && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_drop_beat = in_valid && (r_state >= ST_ITEM_PULSE) && (r_state <= ST_COIN_WAIT);

    // Lowest-index hopper with coins left, i.e. the largest remaining denomination
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = '0;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (r_cnt[i] != 4'd0) begin
                w_pick_valid = 1'b1;
                w_pick       = coin_idx_t'(i);
            end
        end
    end

    // Next state, pulse launch and frame error decode
    always_comb begin
        w_state_d  = r_state;
        w_err      = 1'b0;
        w_pg_start = 1'b0;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (!in_valid) begin
                    w_state_d = ST_IDLE;
                    w_err     = 1'b1;
                end else if (r_beat_cnt == 3'(FRAME_BEATS - 1)) begin
                    if (r_item > 4'(MAX_ITEM)) begin
                        w_state_d = ST_IDLE;
                        w_err     = 1'b1;
                    end else if (r_item == 4'd0) begin
                        w_state_d = ST_COIN_SEL;
                    end else begin
                        w_state_d  = ST_ITEM_PULSE;
                        w_pg_start = 1'b1;
                    end
                end
            end
            ST_ITEM_PULSE: if (w_pg_last) w_state_d = ST_ITEM_WAIT;
            ST_ITEM_WAIT: begin
                if (w_pg_ack)      w_state_d = ST_COIN_SEL;
                else if (w_pg_tmo) w_state_d = ST_DONE;
            end
            ST_COIN_SEL: begin
                if (w_pick_valid) begin
                    w_state_d  = ST_COIN_PULSE;
                    w_pg_start = 1'b1;
                end else begin
                    w_state_d = ST_DONE;
                end
            end
            ST_COIN_PULSE: if (w_pg_last) w_state_d = ST_COIN_WAIT;
            ST_COIN_WAIT: begin
                if (w_pg_ack)      w_state_d = ST_COIN_SEL;
                else if (w_pg_tmo) w_state_d = ST_DONE;
            end
            ST_DONE: w_state_d = in_valid ? ST_CAPTURE : ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    // State, frame storage, coin bookkeeping and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_item       <= '0;
            r_cnt        <= '{default: '0};
            r_sel        <= '0;
            r_total      <= '0;
            r_frame_err  <= 1'b0;
            r_frame_drop <= 1'b0;
            r_drop_run   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_frame_err  <= w_err;
            // One drop pulse per contiguous run of ignored beats
            r_frame_drop <= w_drop_beat && !r_drop_run;
            r_drop_run   <= w_drop_beat;
            if (w_accept) begin
                r_item     <= in_data;
                r_beat_cnt <= 3'd1;
                r_cnt      <= '{default: '0};
                r_total    <= '0;
            end
            if ((r_state == ST_CAPTURE) && in_valid) begin
                r_beat_cnt <= r_beat_cnt + 3'd1;
                for (int i = 0; i < NUM_COINS; i++) begin
                    if (r_beat_cnt == 3'(i + 1)) r_cnt[i] <= in_data;
                end
            end
            if ((r_state == ST_COIN_SEL) && w_pick_valid) r_sel <= w_pick;
            if ((r_state == ST_COIN_WAIT) && w_pg_ack) begin
                r_total <= r_total + denom_value(r_sel);
                for (int i = 0; i < NUM_COINS; i++) begin
                    if (r_sel == coin_idx_t'(i)) r_cnt[i] <= r_cnt[i] - 4'd1;
                end
            end
        end
    end

`ifdef DISP_TIMEOUT_EN
    logic r_fault;

    // Sticky ack-timeout flag, cleared when the next frame is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                 r_fault <= 1'b0;
        else if (w_accept)                                       r_fault <= 1'b0;
        else if (((r_state == ST_ITEM_WAIT) || (r_state == ST_COIN_WAIT)) && w_pg_tmo)
                                                                 r_fault <= 1'b1;
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign item_req        = w_pg_pulse && (r_state == ST_ITEM_PULSE);
    assign coin_pulse      = w_pg_pulse && (r_state == ST_COIN_PULSE);
    assign item_id         = r_item[2:0];
    assign coin_sel        = r_sel;
    assign busy            = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done            = (r_state == ST_DONE);
    assign frame_err       = r_frame_err;
    assign frame_drop      = r_frame_drop;
    assign dispensed_total = r_total;

endmodule

// File: tb/tb_vm_change_dispenser.sv
// Self-checking bench for vm_change_dispenser: directed scenarios plus random frames checked
// against a frame-level payout model. Timeout scenario runs only with DISP_TIMEOUT_EN defined.
module tb_vm_change_dispenser;

    localparam int unsigned TB_PULSE_W     = 4;
    localparam int unsigned TB_ACK_TIMEOUT = 10;

    typedef logic [3:0] frame_t [6];

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        item_req;
    logic [2:0]  item_id;
    logic        item_ack;
    logic [2:0]  coin_sel;
    logic        coin_pulse;
    logic        coin_ack;
    logic        busy;
    logic        done;
    logic        frame_err;
    logic        frame_drop;
    logic [10:0] dispensed_total;
    logic        fault;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state
    int q_items[$];
    int q_coins[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int drop_cnt = 0;

    // Ack responder controls
    logic ack_en   = 1'b1;
    int   ack_dmin = 0;
    int   ack_dmax = 0;

    vm_change_dispenser #(
        .PULSE_W     (TB_PULSE_W),
        .ACK_TIMEOUT (TB_ACK_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .item_req        (item_req),
        .item_id         (item_id),
        .item_ack        (item_ack),
        .coin_sel        (coin_sel),
        .coin_pulse      (coin_pulse),
        .coin_ack        (coin_ack),
        .busy            (busy),
        .done            (done),
        .frame_err       (frame_err),
        .frame_drop      (frame_drop),
        .dispensed_total (dispensed_total),
        .fault           (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: samples shortly after each rising edge, logs units vended and status pulses
    initial begin
        logic prev_item = 1'b0;
        logic prev_coin = 1'b0;
        logic [2:0] prev_sel = '0;
        forever begin
            @(posedge clk);
            #2;
            if (item_req && !prev_item) q_items.push_back(int'(item_id));
            if (coin_pulse && !prev_coin) q_coins.push_back(int'(coin_sel));
            if (coin_pulse && prev_coin) check("coin_sel_stable", coin_sel, prev_sel);
            if (item_req && coin_pulse) check("item_coin_exclusive", 1, 0);
            if (done) done_cnt++;
            if (frame_err) err_cnt++;
            if (frame_drop) drop_cnt++;
            prev_item = item_req;
            prev_coin = coin_pulse;
            prev_sel  = coin_sel;
        end
    end

    // Ack responder: one-cycle ack a random number of cycles after each pulse ends
    initial begin
        int item_cd = -1;
        int coin_cd = -1;
        logic p_item = 1'b0;
        logic p_coin = 1'b0;
        item_ack = 1'b0;
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            item_ack = 1'b0;
            coin_ack = 1'b0;
            if (rst) begin
                item_cd = -1;
                coin_cd = -1;
            end else begin
                if (ack_en && p_item && !item_req) item_cd = $urandom_range(ack_dmax, ack_dmin);
                if (ack_en && p_coin && !coin_pulse) coin_cd = $urandom_range(ack_dmax, ack_dmin);
                if (item_cd == 0) item_ack = 1'b1;
                if (coin_cd == 0) coin_ack = 1'b1;
                if (item_cd >= 0) item_cd--;
                if (coin_cd >= 0) coin_cd--;
            end
            p_item = item_req;
            p_coin = coin_pulse;
        end
    end

    task automatic clear_mon();
        q_items.delete();
        q_coins.delete();
        done_cnt = 0;
        err_cnt  = 0;
        drop_cnt = 0;
    endtask

    // Drive nbeats consecutive beats starting at the current falling edge
    task automatic send_frame(input frame_t f, input int nbeats);
        for (int k = 0; k < nbeats; k++) begin
            in_valid = 1'b1;
            in_data  = f[k];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
    endtask

    // Reference: what a whole frame should produce, from the payout rules
    task automatic expect_frame(input string tag, input frame_t f);
        int exp_q[$];
        int exp_total = 0;
        bit bad = (f[0] > 4'd6);
        int denoms[5] = '{50, 20, 10, 5, 1};
        if (!bad) begin
            for (int d = 0; d < 5; d++) begin
                for (int c = 0; c < int'(f[d+1]); c++) exp_q.push_back(d);
                exp_total += denoms[d] * int'(f[d+1]);
            end
        end
        check({tag, "_err"}, err_cnt, bad ? 1 : 0);
        check({tag, "_done"}, done_cnt, bad ? 0 : 1);
        check({tag, "_nitems"}, q_items.size(), (!bad && f[0] != 0) ? 1 : 0);
        if (!bad && f[0] != 0 && q_items.size() == 1) check({tag, "_item_id"}, q_items[0], f[0]);
        check({tag, "_ncoins"}, q_coins.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < q_coins.size(); i++)
            check({tag, "_coin"}, q_coins[i], exp_q[i]);
        check({tag, "_total"}, dispensed_total, exp_total);
    endtask

    initial begin
        frame_t fr;
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_item_req", item_req, 0);
        check("rst_coin_pulse", coin_pulse, 0);
        check("rst_total", dispensed_total, 0);
        check("rst_fault", fault, 0);
        rst = 1'b0;
        @(negedge clk);

        // Mixed frame, immediate acks
        clear_mon();
        ack_dmin = 0;
        ack_dmax = 0;
        fr = '{4'd3, 4'd2, 4'd0, 4'd1, 4'd1, 4'd2};
        send_frame(fr, 6);
        check("mix_busy", busy, 1);
        wait_done("mix_done_seen", 500);
        @(negedge clk);
        expect_frame("mix", fr);
        check("mix_busy_after", busy, 0);

        // All-zero frame: exact latency, nothing driven
        clear_mon();
        fr = '{default: 4'd0};
        send_frame(fr, 6);
        check("zero_busy_c1", busy, 1);
        @(negedge clk);
        check("zero_done_latency", done, 1);
        check("zero_busy_c2", busy, 0);
        @(negedge clk);
        expect_frame("zero", fr);

        // Short frame
        clear_mon();
        fr = '{4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
        send_frame(fr, 4);
        @(negedge clk);
        check("short_frame_err", frame_err, 1);
        check("short_busy", busy, 0);
        repeat (8) @(negedge clk);
        check("short_errs", err_cnt, 1);
        check("short_no_coins", q_coins.size(), 0);
        check("short_no_items", q_items.size(), 0);
        check("short_no_done", done_cnt, 0);

        // Bad item id
        clear_mon();
        fr = '{4'd7, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        send_frame(fr, 6);
        check("bad_id_frame_err", frame_err, 1);
        repeat (8) @(negedge clk);
        expect_frame("bad_id", fr);

        // Beats during a coin wait are dropped with a single pulse
        clear_mon();
        ack_dmin = 5;
        ack_dmax = 5;
        fr = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        send_frame(fr, 6);
        n = 0;
        while (coin_pulse !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        while (coin_pulse !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        check("drop_reach_wait", n < 200, 1);
        in_valid = 1'b1;
        in_data  = 4'd9;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
        wait_done("drop_done_seen", 200);
        @(negedge clk);
        check("drop_pulses", drop_cnt, 1);
        expect_frame("drop", fr);

        // Random frames, random ack delays
        ack_dmin = 0;
        ack_dmax = 3;
        for (int t = 0; t < 20; t++) begin
            clear_mon();
            fr[0] = 4'($urandom_range(8, 0));
            for (int k = 1; k < 6; k++) fr[k] = 4'($urandom_range(3, 0));
            send_frame(fr, 6);
            if (fr[0] > 4'd6) repeat (3) @(negedge clk);
            else              wait_done("rnd_done_seen", 600);
            @(negedge clk);
            expect_frame("rnd", fr);
            check("rnd_no_drop", drop_cnt, 0);
        end

        // Reset during the second coin pulse
        clear_mon();
        ack_dmin = 1;
        ack_dmax = 1;
        fr = '{4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
        send_frame(fr, 6);
        n = 0;
        while (q_coins.size() < 2 && n < 200) begin @(negedge clk); n++; end
        check("rst_mid_reach", q_coins.size(), 2);
        rst = 1'b1;
        #1;
        check("rst_mid_coin_pulse", coin_pulse, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_total", dispensed_total, 0);
        check("rst_mid_coin_sel", coin_sel, 0);
        check("rst_mid_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_mon();
        fr = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        send_frame(fr, 6);
        wait_done("post_rst_done_seen", 200);
        @(negedge clk);
        expect_frame("post_rst", fr);

`ifdef DISP_TIMEOUT_EN
        // Coin ack never arrives
        clear_mon();
        ack_en = 1'b0;
        fr = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
        send_frame(fr, 6);
        n = 0;
        while (coin_pulse !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        while (coin_pulse !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        n = 1;
        while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("tmo_latency", n, TB_ACK_TIMEOUT + 1);
        check("tmo_fault", fault, 1);
        check("tmo_total", dispensed_total, 0);
        ack_en = 1'b1;
        fr = '{default: 4'd0};
        send_frame(fr, 6);
        check("tmo_fault_cleared", fault, 0);
        wait_done("tmo_next_done", 50);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
